// File: rtl/ex_muldiv_iter_if.sv
// Request/response bundle for the iterative RV32M multiply/divide unit.
// Handshake: a request transfers on a rising edge where in_valid & in_ready & !kill;
// a result transfers on a rising edge where out_valid & out_ready & !kill. out_valid,
// out_data and out_tag hold steady until that transfer, and kill discards any work in flight.
interface ex_muldiv_iter_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       in_op;
    logic [XLEN-1:0]  in_rs1;
    logic [XLEN-1:0]  in_rs2;
    logic [TAG_W-1:0] in_tag;
    logic             kill;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  out_data;
    logic [TAG_W-1:0] out_tag;
    logic             busy;

    // Pipeline side: issues requests, consumes results, drives kill.
    modport master (
        output in_valid, in_op, in_rs1, in_rs2, in_tag, kill, out_ready,
        input  in_ready, out_valid, out_data, out_tag, busy
    );

    // Execution unit side.
    modport slave (
        input  in_valid, in_op, in_rs1, in_rs2, in_tag, kill, out_ready,
        output in_ready, out_valid, out_data, out_tag, busy
    );
endinterface

// File: rtl/ex_muldiv_iter.sv
// Iterative RV32M multiply/divide unit for the EX stage (radix-2, one bit per cycle).
// Multiply is shift-add on a 2*XLEN accumulator; divide is restoring shift-subtract.
// Both iterate on operand magnitudes and the sign is applied in the FIX state.
// Optional feature macro: MULDIV_FAST_MUL_EN -- when defined, multiplies use a
// single-cycle combinational multiplier and skip CALC (IDLE -> FIX).
module ex_muldiv_iter #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    ex_muldiv_iter_if.slave bus,
    output logic [1:0]      dbg_state
);
    localparam int CNT_W = $clog2(XLEN);

    localparam logic [2:0] OP_MUL    = 3'd0;
    localparam logic [2:0] OP_MULH   = 3'd1;
    localparam logic [2:0] OP_MULHSU = 3'd2;
    localparam logic [2:0] OP_MULHU  = 3'd3;
    localparam logic [2:0] OP_DIV    = 3'd4;
    localparam logic [2:0] OP_DIVU   = 3'd5;
    localparam logic [2:0] OP_REM    = 3'd6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t state;
    state_t state_nxt;

    // Captured operation context
    logic [2:0]        op_q;
    logic [XLEN-1:0]   opnd_q;     // multiplicand (mul) or divisor (div) magnitude
    logic [2*XLEN-1:0] acc_q;      // mul: {partial, multiplier}; div: {remainder, dividend/quotient}
    logic              neg_q;      // product / quotient must be negated
    logic              rneg_q;     // remainder must be negated
    logic [CNT_W-1:0]  cnt_q;

    // Request decode
    logic              accept;
    logic              is_div_in;
    logic              sgn_a_in;
    logic              sgn_b_in;
    logic              neg_a_in;
    logic              neg_b_in;
    logic [XLEN-1:0]   abs_a_in;
    logic [XLEN-1:0]   abs_b_in;
    logic              div_zero_in;
    logic              div_ovf_in;
    logic              special_in;
    logic              fast_in;
    logic [XLEN-1:0]   special_data;

    // Iteration and fix-up datapath
    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     div_shift;
    logic [XLEN:0]     div_diff;
    logic [2*XLEN-1:0] acc_step;
    logic [2*XLEN-1:0] prod_signed;
    logic [XLEN-1:0]   quo_signed;
    logic [XLEN-1:0]   rem_signed;
    logic [XLEN-1:0]   fix_data;

    assign accept    = bus.in_valid && (state == IDLE) && !bus.kill;
    assign is_div_in = bus.in_op[2];
    assign sgn_a_in  = (bus.in_op == OP_MULH) || (bus.in_op == OP_MULHSU) ||
                       (bus.in_op == OP_DIV)  || (bus.in_op == OP_REM);
    assign sgn_b_in  = (bus.in_op == OP_MULH) || (bus.in_op == OP_DIV) || (bus.in_op == OP_REM);
    assign neg_a_in  = sgn_a_in && bus.in_rs1[XLEN-1];
    assign neg_b_in  = sgn_b_in && bus.in_rs2[XLEN-1];
    assign abs_a_in  = neg_a_in ? -bus.in_rs1 : bus.in_rs1;
    assign abs_b_in  = neg_b_in ? -bus.in_rs2 : bus.in_rs2;

    // Divide special cases finish straight from IDLE
    assign div_zero_in = is_div_in && (bus.in_rs2 == '0);
    assign div_ovf_in  = ((bus.in_op == OP_DIV) || (bus.in_op == OP_REM)) &&
                         (bus.in_rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (bus.in_rs2 == '1);
    assign special_in  = div_zero_in || div_ovf_in;

    // Results of the special cases; op[1] distinguishes REM/REMU from DIV/DIVU
    always_comb begin
        special_data = '0;
        if (div_zero_in) begin
            special_data = bus.in_op[1] ? bus.in_rs1 : '1;
        end else if (div_ovf_in) begin
            special_data = bus.in_op[1] ? '0 : bus.in_rs1;
        end
    end

`ifdef MULDIV_FAST_MUL_EN
    logic [2*XLEN-1:0] fast_prod;
    assign fast_prod = {{XLEN{1'b0}}, abs_a_in} * {{XLEN{1'b0}}, abs_b_in};
    assign fast_in   = !is_div_in;
`else
    assign fast_in   = 1'b0;
`endif

    // One radix-2 step of shift-add multiply or restoring divide
    always_comb begin
        mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        div_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
        div_diff  = div_shift - {1'b0, opnd_q};
        if (op_q[2]) begin
            if (!div_diff[XLEN]) begin
                acc_step = {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
            end else begin
                acc_step = {div_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
            end
        end else begin
            acc_step = {mul_sum, acc_q[XLEN-1:1]};
        end
    end

    // Sign fix-up and result word selection
    always_comb begin
        prod_signed = neg_q  ? -acc_q : acc_q;
        quo_signed  = neg_q  ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
        rem_signed  = rneg_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
        case (op_q)
            OP_MUL:                       fix_data = prod_signed[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: fix_data = prod_signed[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:              fix_data = quo_signed;
            default:                      fix_data = rem_signed;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; kill overrides every other transition
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (special_in) begin
                        state_nxt = DONE;
                    end else if (fast_in) begin
                        state_nxt = FIX;
                    end else begin
                        state_nxt = CALC;
                    end
                end
            end
            CALC: begin
                if (cnt_q == CNT_W'(XLEN - 1)) begin
                    state_nxt = FIX;
                end
            end
            FIX:  state_nxt = DONE;
            DONE: begin
                if (bus.out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (bus.kill) begin
            state_nxt = IDLE;
        end
    end

    // Operand capture, iteration and result register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_q         <= '0;
            opnd_q       <= '0;
            acc_q        <= '0;
            neg_q        <= 1'b0;
            rneg_q       <= 1'b0;
            cnt_q        <= '0;
            bus.out_data <= '0;
            bus.out_tag  <= '0;
        end else if (accept) begin
            op_q        <= bus.in_op;
            neg_q       <= neg_a_in ^ neg_b_in;
            rneg_q      <= neg_a_in;
            cnt_q       <= '0;
            bus.out_tag <= bus.in_tag;
            if (special_in) begin
                bus.out_data <= special_data;
            end
            if (is_div_in) begin
                acc_q  <= {{XLEN{1'b0}}, abs_a_in};
                opnd_q <= abs_b_in;
            end else begin
                acc_q  <= {{XLEN{1'b0}}, abs_b_in};
                opnd_q <= abs_a_in;
            end
`ifdef MULDIV_FAST_MUL_EN
            if (!is_div_in) begin
                acc_q <= fast_prod;
            end
`endif
        end else if (!bus.kill) begin
            if (state == CALC) begin
                acc_q <= acc_step;
                cnt_q <= cnt_q + 1'b1;
            end
            if (state == FIX) begin
                bus.out_data <= fix_data;
            end
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.busy      = (state != IDLE);
    assign dbg_state     = state;
endmodule

// File: tb/tb_ex_muldiv_iter.sv
// Self-checking bench for ex_muldiv_iter: directed vector table, handshake/kill/reset
// sequences and a randomized regression against an arithmetic reference model.
module tb_ex_muldiv_iter;
    localparam int XLEN  = 32;
    localparam int TAG_W = 5;
    localparam int N_RAND = 1000;
`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 2;
`else
    localparam int MUL_LAT = XLEN + 2;
`endif
    localparam int DIV_LAT = XLEN + 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] dbg_state;

    ex_muldiv_iter_if #(.XLEN(XLEN), .TAG_W(TAG_W)) bus ();

    ex_muldiv_iter #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .dbg_state(dbg_state)
    );

    // Clock
    always #5 clk = ~clk;

    // Watchdog
    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int n_checks = 0;
    int n_fail   = 0;
    logic [XLEN-1:0]  exp_q[$];
    logic [TAG_W-1:0] exp_tag_q[$];

    typedef struct {
        logic [2:0]      op;
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        logic [XLEN-1:0] exp;
        int              lat;
    } vec_t;

    vec_t vecs[16];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: plain 64-bit arithmetic following the RV32M rules
    function automatic logic [31:0] ref_model(input logic [2:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        logic signed [63:0] ub_s;
        logic [63:0] ua;
        logic [63:0] ub;
        logic [63:0] p;
        logic ovf;
        sa   = {{32{a[31]}}, a};
        sb   = {{32{b[31]}}, b};
        ua   = {32'd0, a};
        ub   = {32'd0, b};
        ub_s = ub;
        ovf  = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (op)
            3'd0: begin p = ua * ub;   return p[31:0];  end
            3'd1: begin p = sa * sb;   return p[63:32]; end
            3'd2: begin p = sa * ub_s; return p[63:32]; end
            3'd3: begin p = ua * ub;   return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ovf) return a;
                return $signed(a) / $signed(b);
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (ovf) return 32'd0;
                return $signed(a) % $signed(b);
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int exp_latency(input logic [2:0] op, input logic [31:0] a,
                                       input logic [31:0] b);
        if (op[2] && b == 0) return 1;
        if ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return op[2] ? DIV_LAT : MUL_LAT;
    endfunction

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 15));
            4: return -32'($urandom_range(1, 15));
            default: return $urandom;
        endcase
    endfunction

    // Driver: called at posedge+1 with the unit idle. Issues one request, measures
    // edges from accept until out_valid is seen, optionally stalls, then consumes.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [TAG_W-1:0] tag, input int hold,
                         output logic [31:0] data, output logic [TAG_W-1:0] otag,
                         output int lat);
        logic [31:0] first;
        data = '0;
        otag = '0;
        bus.in_valid = 1'b1;
        bus.in_op    = op;
        bus.in_rs1   = a;
        bus.in_rs2   = b;
        bus.in_tag   = tag;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.in_op    = 3'($urandom);
        bus.in_rs1   = $urandom;
        bus.in_rs2   = $urandom;
        lat = 1;
        while (!bus.out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!bus.out_valid) begin
            check("result_timeout", {63'd0, bus.out_valid}, 64'd1);
            return;
        end
        first = bus.out_data;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            if (!bus.out_valid || bus.out_data !== first || bus.in_ready)
                check("stall_stable", {bus.out_valid, bus.in_ready, bus.out_data},
                      {1'b1, 1'b0, first});
        end
        data = bus.out_data;
        otag = bus.out_tag;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
    endtask

    initial begin
        logic [31:0]      data;
        logic [TAG_W-1:0] otag;
        logic [31:0]      a;
        logic [31:0]      b;
        logic [2:0]       op;
        logic [TAG_W-1:0] tag;
        int               lat;
        int               hold;

        bus.in_valid  = 1'b0;
        bus.in_op     = '0;
        bus.in_rs1    = '0;
        bus.in_rs2    = '0;
        bus.in_tag    = '0;
        bus.kill      = 1'b0;
        bus.out_ready = 1'b0;

        // Reset
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("reset_out_valid", {63'd0, bus.out_valid}, 64'd0);
        check("reset_in_ready",  {63'd0, bus.in_ready},  64'd1);
        check("reset_busy",      {63'd0, bus.busy},      64'd0);
        check("reset_out_data",  {32'd0, bus.out_data},  64'd0);
        check("reset_out_tag",   {59'd0, bus.out_tag},   64'd0);

        // Directed vector table
        vecs[0]  = '{3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, MUL_LAT};
        vecs[1]  = '{3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, MUL_LAT};
        vecs[2]  = '{3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, MUL_LAT};
        vecs[3]  = '{3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_LAT};
        vecs[4]  = '{3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, DIV_LAT};
        vecs[5]  = '{3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, DIV_LAT};
        vecs[6]  = '{3'd5, 32'd100,        32'd7,         32'd14,        DIV_LAT};
        vecs[7]  = '{3'd7, 32'd100,        32'd7,         32'd2,         DIV_LAT};
        vecs[8]  = '{3'd4, 32'd5,          32'd0,         32'hFFFF_FFFF, 1};
        vecs[9]  = '{3'd6, 32'd5,          32'd0,         32'd5,         1};
        vecs[10] = '{3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1};
        vecs[11] = '{3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1};
        vecs[12] = '{3'd5, 32'd9,          32'd0,         32'hFFFF_FFFF, 1};
        vecs[13] = '{3'd7, 32'd9,          32'd0,         32'd9,         1};
        vecs[14] = '{3'd4, 32'd7,          32'hFFFF_FFFE, 32'hFFFF_FFFD, DIV_LAT};
        vecs[15] = '{3'd6, 32'd7,          32'hFFFF_FFFE, 32'd1,         DIV_LAT};
        for (int i = 0; i < 16; i++) begin
            tag = (i == 0) ? TAG_W'(5) : TAG_W'(i + 3);
            issue(vecs[i].op, vecs[i].a, vecs[i].b, tag, 0, data, otag, lat);
            check($sformatf("vec%0d_data", i), {32'd0, data}, {32'd0, vecs[i].exp});
            check($sformatf("vec%0d_tag", i),  {59'd0, otag}, {59'd0, tag});
            check($sformatf("vec%0d_lat", i),  64'(lat),      64'(vecs[i].lat));
        end

        // Backpressure in DONE with a request pending: nothing may be accepted
        bus.in_valid = 1'b1;
        bus.in_op    = 3'd5;
        bus.in_rs1   = 32'd100;
        bus.in_rs2   = 32'd7;
        bus.in_tag   = 5'd3;
        @(posedge clk); #1;
        bus.in_op    = 3'd3;
        bus.in_rs1   = 32'd1;
        lat = 1;
        while (!bus.out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        check("bp_latency", 64'(lat), 64'(DIV_LAT));
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check("bp_out_valid", {63'd0, bus.out_valid}, 64'd1);
            check("bp_out_data",  {32'd0, bus.out_data},  64'd14);
            check("bp_in_ready",  {63'd0, bus.in_ready},  64'd0);
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b0;
        check("bp_no_accept_busy", {63'd0, bus.busy},      64'd0);
        check("bp_out_valid_drop", {63'd0, bus.out_valid}, 64'd0);

        // Kill during CALC cycle 3, then a fresh request right after
        bus.in_valid = 1'b1;
        bus.in_op    = 3'd5;
        bus.in_rs1   = 32'd1000;
        bus.in_rs2   = 32'd3;
        bus.in_tag   = 5'd11;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        bus.kill = 1'b1;
        @(posedge clk); #1;
        bus.kill = 1'b0;
        check("kill_busy",      {63'd0, bus.busy},      64'd0);
        check("kill_out_valid", {63'd0, bus.out_valid}, 64'd0);
        check("kill_in_ready",  {63'd0, bus.in_ready},  64'd1);
        issue(3'd5, 32'd100, 32'd7, 5'd12, 0, data, otag, lat);
        check("post_kill_data", {32'd0, data}, 64'd14);
        check("post_kill_tag",  {59'd0, otag}, 64'd12);
        check("post_kill_lat",  64'(lat),      64'(DIV_LAT));

        // kill beats in_valid in IDLE
        bus.in_valid = 1'b1;
        bus.kill     = 1'b1;
        bus.in_op    = 3'd4;
        bus.in_rs2   = 32'd0;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.kill     = 1'b0;
        check("kill_vs_valid_busy", {63'd0, bus.busy}, 64'd0);

        // kill in DONE drops out_valid without out_ready
        bus.in_valid = 1'b1;
        bus.in_op    = 3'd4;
        bus.in_rs1   = 32'd5;
        bus.in_rs2   = 32'd0;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        check("special_valid", {63'd0, bus.out_valid}, 64'd1);
        bus.kill = 1'b1;
        @(posedge clk); #1;
        bus.kill = 1'b0;
        check("kill_done_valid", {63'd0, bus.out_valid}, 64'd0);
        check("kill_done_busy",  {63'd0, bus.busy},      64'd0);

        // Synchronous reset mid-CALC after a completed op left data in place
        issue(3'd5, 32'd100, 32'd7, 5'd21, 0, data, otag, lat);
        check("pre_reset_data", {32'd0, data}, 64'd14);
        bus.in_valid = 1'b1;
        bus.in_op    = 3'd3;
        bus.in_rs1   = 32'd3;
        bus.in_rs2   = 32'd5;
        bus.in_tag   = 5'd9;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("rst_mid_out_valid", {63'd0, bus.out_valid}, 64'd0);
        check("rst_mid_out_data",  {32'd0, bus.out_data},  64'd0);
        check("rst_mid_out_tag",   {59'd0, bus.out_tag},   64'd0);
        check("rst_mid_busy",      {63'd0, bus.busy},      64'd0);

        // Random regression with random gaps and backpressure
        for (int n = 0; n < N_RAND; n++) begin
            op   = 3'($urandom);
            a    = rand_operand();
            b    = rand_operand();
            tag  = TAG_W'($urandom);
            hold = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0;
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            exp_q.push_back(ref_model(op, a, b));
            exp_tag_q.push_back(tag);
            issue(op, a, b, tag, hold, data, otag, lat);
            if (data !== exp_q[0] || otag !== exp_tag_q[0] || lat != exp_latency(op, a, b)) begin
                check($sformatf("rand%0d op%0d a=%0h b=%0h", n, op, a, b),
                      {data, 27'd0, otag}, {exp_q[0], 27'd0, exp_tag_q[0]});
                check($sformatf("rand%0d_lat", n), 64'(lat), 64'(exp_latency(op, a, b)));
            end else begin
                n_checks++;
            end
            void'(exp_q.pop_front());
            void'(exp_tag_q.pop_front());
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
